// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: sample width, signed pixel type and a signed max
// helper used by the pooling and ReLU stages.
package cnn_pkg;

  localparam int DW = 10;

  typedef logic signed [DW-1:0] pixel_t;

  localparam pixel_t MAX_S = {1'b0, {(DW-1){1'b1}}};
  localparam pixel_t MIN_S = {1'b1, {(DW-1){1'b0}}};

  // Ties return a, which equals b, so the caller never needs to care which one is kept.
  function automatic pixel_t max_s(input pixel_t a, input pixel_t b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Simple dual-port line buffer with a registered, read-enabled output.
// The contents are never cleared.
module pool_linebuf #(
  parameter int DEPTH = 14,
  parameter int AW    = 4,
  parameter int DW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // The read register only updates when re is high, so it holds its value while the stream is stalled.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/maxpool2x2_lb.sv
// Streaming 2x2 / stride-2 signed max-pool. Even rows store their pairwise maxima in a
// half-width line buffer. Odd rows combine with it and emit one pooled pixel per window.
module maxpool2x2_lb
  import cnn_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int AW    = 11
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] xin,
  output logic                 out_valid,
  output logic signed [DW-1:0] out,
  output logic                 frame_done
);

  localparam int  LB_DEPTH = IMG_W / 2;
  localparam int  LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int  RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam bit  W_ODD    = (IMG_W % 2) == 1;
  localparam bit  H_ODD    = (IMG_H % 2) == 1;

  logic [AW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  pixel_t           r_hold;
  pixel_t           r_out;
  logic             r_out_valid;
  logic             r_frame_done;

  logic [AW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_pair_ok;
  logic             w_odd_col;
  logic             w_odd_row;
  logic             w_lb_we;
  logic             w_lb_re;
  logic             w_emit;
  logic [LB_AW-1:0] w_lb_addr;
  logic [DW-1:0]    w_lb_rdata;
  pixel_t           w_lb_rd;
  pixel_t           w_hmax;

  // start acts as a position override for this cycle, so a coincident pixel lands at (0,0).
  assign w_col      = start ? '0 : r_col;
  assign w_row      = start ? '0 : r_row;
  assign w_col_last = (w_col == AW'(IMG_W - 1));
  assign w_row_last = (w_row == RW'(IMG_H - 1));
  assign w_odd_col  = w_col[0];
  assign w_odd_row  = w_row[0];

  // An odd trailing column or row has no partner, so it never touches the buffer or the output.
  assign w_pair_ok  = !(W_ODD && w_col_last) && !(H_ODD && w_row_last);

  assign w_lb_addr  = w_col[LB_AW:1];
  assign w_hmax     = max_s(r_hold, pixel_t'(xin));
  assign w_lb_rd    = pixel_t'(w_lb_rdata);

  assign w_lb_we    = in_valid && !w_odd_row &&  w_odd_col && w_pair_ok;
  assign w_lb_re    = in_valid &&  w_odd_row && !w_odd_col && w_pair_ok;
  assign w_emit     = in_valid &&  w_odd_row &&  w_odd_col && w_pair_ok;

  pool_linebuf #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW),
    .DW    (DW)
  ) u_linebuf (
    .clk   (clk),
    .we    (w_lb_we),
    .waddr (w_lb_addr),
    .wdata (w_hmax),
    .re    (w_lb_re),
    .raddr (w_lb_addr),
    .rdata (w_lb_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col        <= '0;
      r_row        <= '0;
      r_hold       <= '0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= w_emit;
      r_frame_done <= in_valid && w_col_last && w_row_last;
      if (in_valid) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
        if (!w_odd_col) begin
          r_hold <= pixel_t'(xin);
        end
        if (w_emit) begin
          r_out <= max_s(w_lb_rd, w_hmax);
        end
      end else if (start) begin
        r_col <= '0;
        r_row <= '0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out        = r_out;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool2x2_lb.sv
// Directed bench for maxpool2x2_lb: a 4x4 and a 5x5 instance share one stimulus stream.
// A start pulse resynchronises both instances before each frame.
module tb_maxpool2x2_lb;
  import cnn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 resetn;
  logic                 start;
  logic                 in_valid;
  logic signed [DW-1:0] xin;
  logic                 ov4, fd4, ov5, fd5;
  logic signed [DW-1:0] o4, o5;

  maxpool2x2_lb #(.IMG_W(4), .IMG_H(4), .AW(11)) dut4 (
    .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .xin(xin),
    .out_valid(ov4), .out(o4), .frame_done(fd4)
  );

  maxpool2x2_lb #(.IMG_W(5), .IMG_H(5), .AW(11)) dut5 (
    .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .xin(xin),
    .out_valid(ov5), .out(o5), .frame_done(fd5)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic acc_last = 1'b0;

  int q_val4[$], q_cyc4[$], q_acc4[$], q_fd4[$];
  int q_val5[$], q_cyc5[$], q_acc5[$], q_fd5[$];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    acc_last <= in_valid;
  end

  // Log every pulse, and whether a pixel was accepted on the edge that produced it.
  always @(negedge clk) begin
    if (ov4) begin
      q_val4.push_back(int'(o4));
      q_cyc4.push_back(cyc);
      q_acc4.push_back(int'(acc_last));
    end
    if (fd4) q_fd4.push_back(cyc);
    if (ov5) begin
      q_val5.push_back(int'(o5));
      q_cyc5.push_back(cyc);
      q_acc5.push_back(int'(acc_last));
    end
    if (fd5) q_fd5.push_back(cyc);
  end

  typedef struct {
    bit big;
    int n_pix;
    int gap;
    int pix[25];
    int exp_val[4];
    int exp_off[4];
    int fd_off;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_q();
    q_val4.delete(); q_cyc4.delete(); q_acc4.delete(); q_fd4.delete();
    q_val5.delete(); q_cyc5.delete(); q_acc5.delete(); q_fd5.delete();
  endtask

  task automatic frame_start();
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on a negedge; the pixel is accepted on the following posedge.
  task automatic send(input int v, input int gap);
    in_valid = 1'b1;
    xin = pixel_t'(v);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_run(input int tag, input bit big, input int t0,
                           input int ev[4], input int eo[4], input int fdo);
    int vals[$];
    int cycs[$];
    int accs[$];
    int fds[$];
    if (big) begin
      vals = q_val5; cycs = q_cyc5; accs = q_acc5; fds = q_fd5;
    end else begin
      vals = q_val4; cycs = q_cyc4; accs = q_acc4; fds = q_fd4;
    end
    chk($sformatf("t%0d_out_count", tag), vals.size(), 4);
    for (int i = 0; i < 4 && i < vals.size(); i++) begin
      chk($sformatf("t%0d_out%0d_value", tag, i), vals[i], ev[i]);
      chk($sformatf("t%0d_out%0d_cycle", tag, i), cycs[i] - t0, eo[i]);
      chk($sformatf("t%0d_out%0d_after_accept", tag, i), accs[i], 1);
    end
    chk($sformatf("t%0d_frame_done_count", tag), fds.size(), 1);
    if (fds.size() > 0) chk($sformatf("t%0d_frame_done_cycle", tag), fds[0] - t0, fdo);
    $display("run %0d: %0d outputs observed, checks so far %0d", tag, vals.size(), checks);
  endtask

  int t0;
  int ramp_val[4] = '{5, 7, 13, 15};
  int ramp_off[4] = '{6, 8, 14, 16};

  initial begin
    // 0: 4x4 ramp, 1: all-negative, 2: extremes, 3: ramp with 3-cycle stalls, 4: 5x5 ramp
    for (int t = 0; t < 5; t++) begin
      vecs[t].big = 1'b0; vecs[t].n_pix = 16; vecs[t].gap = 0; vecs[t].fd_off = 16;
      vecs[t].exp_off = '{6, 8, 14, 16};
      for (int k = 0; k < 25; k++) vecs[t].pix[k] = k;
    end
    vecs[0].exp_val = '{5, 7, 13, 15};
    for (int k = 0; k < 16; k++) vecs[1].pix[k] = k - 16;
    vecs[1].exp_val = '{-11, -9, -3, -1};
    for (int k = 0; k < 16; k++) vecs[2].pix[k] = -512;
    vecs[2].pix[0] = 511; vecs[2].pix[5] = 510; vecs[2].pix[7] = 511;
    vecs[2].pix[12] = 511; vecs[2].pix[11] = 0;
    vecs[2].exp_val = '{511, 511, 511, 0};
    vecs[3].gap = 3;
    vecs[3].exp_val = '{5, 7, 13, 15};
    vecs[3].exp_off = '{21, 29, 53, 61};
    vecs[3].fd_off = 61;
    vecs[4].big = 1'b1; vecs[4].n_pix = 25; vecs[4].fd_off = 25;
    vecs[4].exp_val = '{6, 8, 16, 18};
    vecs[4].exp_off = '{7, 9, 17, 19};

    resetn = 1'b0; start = 1'b0; in_valid = 1'b0; xin = '0;
    repeat (2) @(negedge clk);
    chk("reset_out", int'(o4), 0);
    chk("reset_out_valid", int'(ov4), 0);
    chk("reset_frame_done", int'(fd4), 0);
    resetn = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      frame_start();
      clear_q();
      t0 = cyc;
      for (int k = 0; k < vecs[t].n_pix; k++) send(vecs[t].pix[k], vecs[t].gap);
      repeat (4) @(negedge clk);
      check_run(t, vecs[t].big, t0, vecs[t].exp_val, vecs[t].exp_off, vecs[t].fd_off);
    end

    // Aborted frame: five pixels, then start coincident with the new frame's first pixel.
    frame_start();
    clear_q();
    for (int k = 0; k < 5; k++) send(100 + k, 0);
    start = 1'b1;
    t0 = cyc;
    send(0, 0);
    start = 1'b0;
    for (int k = 1; k < 16; k++) send(k, 0);
    repeat (4) @(negedge clk);
    check_run(5, 1'b0, t0, ramp_val, ramp_off, 16);
    chk("out_holds_between_pulses", int'(o4), 15);

    // Reset asserted in row 1. Outputs must clear, and the next pixel must be (0,0).
    frame_start();
    for (int k = 0; k < 5; k++) send(k, 0);
    resetn = 1'b0;
    #1;
    chk("midreset_out", int'(o4), 0);
    chk("midreset_out_valid", int'(ov4), 0);
    chk("midreset_frame_done", int'(fd4), 0);
    repeat (2) @(negedge clk);
    chk("midreset_out_late", int'(o4), 0);
    resetn = 1'b1;
    @(negedge clk);
    clear_q();
    t0 = cyc;
    for (int k = 0; k < 16; k++) send(k, 0);
    repeat (4) @(negedge clk);
    check_run(6, 1'b0, t0, ramp_val, ramp_off, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
